// File: rtl/branch_predict_ctrl_pkg.sv
// Shared constants and types for the fetch-stage branch predictor.
// Counter encodings, entry state layout and the tag-width helper live here.
package branch_predict_ctrl_pkg;

    localparam int BHT_IDX_W_DEF = 6;
    localparam int CNT_W         = 2;
    localparam int TARGET_W      = 32;

    localparam logic [CNT_W-1:0] CNT_SNT = 2'b00;
    localparam logic [CNT_W-1:0] CNT_WNT = 2'b01;
    localparam logic [CNT_W-1:0] CNT_WT  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ST  = 2'b11;

    // Per-entry state that must be reset; tag and target arrays are kept separately.
    typedef struct packed {
        logic             valid;
        logic [CNT_W-1:0] cnt;
    } bht_state_t;

    function automatic int tag_width(input int idx_w);
        return 30 - idx_w;
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// Fetch/decode signal bundle between the pipeline/hazard logic and the predictor.
interface branch_predict_ctrl_if;

    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        StallF;
    logic        StallD;
    logic        BranchD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic [31:0] PCPlus4D;
    logic        PredTakenF;
    logic [31:0] NextPCF;
    logic        FlushD;
    logic        MispredictD;

    modport master (
        output PCF, PCPlus4F, StallF, StallD, BranchD, PCSrcD, PCBranchD, PCPlus4D,
        input  PredTakenF, NextPCF, FlushD, MispredictD
    );

    modport slave (
        input  PCF, PCPlus4F, StallF, StallD, BranchD, PCSrcD, PCBranchD, PCPlus4D,
        output PredTakenF, NextPCF, FlushD, MispredictD
    );

endinterface

// File: rtl/bp_sat_counter.sv
// Combinational next-state of a 2-bit saturating branch counter.
module bp_sat_counter
    import branch_predict_ctrl_pkg::*;
(
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             taken_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (taken_i) begin
            if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'b01;
        end else begin
            if (cnt_i != CNT_SNT) cnt_o = cnt_i - 2'b01;
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB/BHT branch predictor owning the fetch next-PC select.
// Optional BRANCH_PRED_STATS_EN adds BranchCnt/MispredCnt statistics outputs.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int               BHT_IDX_W = BHT_IDX_W_DEF,
    parameter logic [CNT_W-1:0] CNT_INIT  = CNT_WNT
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predict_ctrl_if.slave bus
`ifdef BRANCH_PRED_STATS_EN
    ,
    output logic [31:0]          BranchCnt,
    output logic [31:0]          MispredCnt
`endif
);

    localparam int DEPTH = 2 ** BHT_IDX_W;
    localparam int TAG_W = tag_width(BHT_IDX_W);

    bht_state_t           st_q     [DEPTH];
    bht_state_t           st_d     [DEPTH];
    logic [TAG_W-1:0]     tag_q    [DEPTH];
    logic [TARGET_W-1:0]  target_q [DEPTH];
    logic [DEPTH-1:0]     entry_we;

    logic [BHT_IDX_W-1:0] idx_f;
    logic [TAG_W-1:0]     tag_f;
    logic                 hit_f;
    logic                 pred_taken_f;
    logic [31:0]          pred_target_f;

    logic                 pred_taken_d_q,  pred_taken_d_d;
    logic [31:0]          pred_target_d_q, pred_target_d_d;
    logic [31:0]          pcd_q,           pcd_d;

    logic [BHT_IDX_W-1:0] idx_d;
    logic [TAG_W-1:0]     tag_d;
    logic                 resolve_d;
    logic                 mispredict_d;
    logic [CNT_W-1:0]     cnt_trained;
    logic [31:0]          next_pc;
    logic                 unused_ok;

    // Fetch lookup reads the registered tables, so it always sees pre-training state.
    assign idx_f         = bus.PCF[BHT_IDX_W+1:2];
    assign tag_f         = bus.PCF[31:BHT_IDX_W+2];
    assign hit_f         = st_q[idx_f].valid && (tag_q[idx_f] == tag_f);
    assign pred_taken_f  = hit_f && st_q[idx_f].cnt[1];
    assign pred_target_f = target_q[idx_f];

    assign idx_d     = pcd_q[BHT_IDX_W+1:2];
    assign tag_d     = pcd_q[31:BHT_IDX_W+2];
    assign resolve_d = bus.BranchD && !bus.StallD;

    assign mispredict_d = resolve_d &&
        ((bus.PCSrcD != pred_taken_d_q) ||
         (bus.PCSrcD && pred_taken_d_q && (pred_target_d_q != bus.PCBranchD)));

    bp_sat_counter u_sat_counter (
        .cnt_i   (st_q[idx_d].cnt),
        .taken_i (bus.PCSrcD),
        .cnt_o   (cnt_trained)
    );

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = resolve_d && (idx_d == BHT_IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            st_d[i] = st_q[i];
            if (entry_we[i]) begin
                st_d[i].cnt = cnt_trained;
                if (bus.PCSrcD) st_d[i].valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i] <= '{valid: 1'b0, cnt: CNT_INIT};
            end
        end else begin
            st_q <= st_d;
        end
    end

    // Tag/target need no reset: an entry is ignored until its valid bit is set.
    always_ff @(posedge clk) begin
        if (resolve_d && bus.PCSrcD) begin
            tag_q[idx_d]    <= tag_d;
            target_q[idx_d] <= bus.PCBranchD;
        end
    end

    always_comb begin
        pred_taken_d_d  = pred_taken_d_q;
        pred_target_d_d = pred_target_d_q;
        pcd_d           = pcd_q;
        if (mispredict_d) begin
            pred_taken_d_d  = 1'b0;
            pred_target_d_d = '0;
            pcd_d           = '0;
        end else if (!bus.StallD) begin
            pred_taken_d_d  = pred_taken_f;
            pred_target_d_d = pred_target_f;
            pcd_d           = bus.PCF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_taken_d_q  <= 1'b0;
            pred_target_d_q <= '0;
            pcd_q           <= '0;
        end else begin
            pred_taken_d_q  <= pred_taken_d_d;
            pred_target_d_q <= pred_target_d_d;
            pcd_q           <= pcd_d;
        end
    end

    // Redirect wins over the fetch prediction; StallF is left to the PC register.
    always_comb begin
        next_pc = bus.PCPlus4F;
        if (mispredict_d) begin
            next_pc = bus.PCSrcD ? bus.PCBranchD : bus.PCPlus4D;
        end else if (pred_taken_f) begin
            next_pc = pred_target_f;
        end
    end

    assign bus.PredTakenF  = pred_taken_f;
    assign bus.NextPCF     = next_pc;
    assign bus.FlushD      = mispredict_d;
    assign bus.MispredictD = mispredict_d;

    assign unused_ok = ^{bus.PCF[1:0], pcd_q[1:0], bus.StallF};

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve_d)    branch_cnt_d  = branch_cnt_q + 32'd1;
        if (mispredict_d) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BranchCnt  = branch_cnt_q;
    assign MispredCnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: cold/warm prediction, saturation, stall,
// aliasing, target mismatch, same-cycle read-before-write and mid-run reset.
module tb_branch_predict_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_br = 0;
    int   exp_mis = 0;
    logic cur_resolve = 1'b0;
    logic cur_mis = 1'b0;

    branch_predict_ctrl_if bus ();

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;
`endif

    branch_predict_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef BRANCH_PRED_STATS_EN
        ,
        .BranchCnt  (branch_cnt),
        .MispredCnt (mispred_cnt)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [31:0] PC_BR    = 32'h0040_0010;
    localparam logic [31:0] PC_BR4   = 32'h0040_0014;
    localparam logic [31:0] PC_TGT   = 32'h0040_0040;
    localparam logic [31:0] PC_TGT4  = 32'h0040_0044;
    localparam logic [31:0] PC_TGT2  = 32'h0040_0080;
    localparam logic [31:0] PC_ALIAS = 32'h0040_0110;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-12s observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle's inputs just after the rising edge, then settle to the falling edge.
    task automatic step(input logic [31:0] pcf, input logic br, input logic src,
                        input logic [31:0] tgt, input logic [31:0] p4d, input logic stl);
        bus.PCF       = pcf;
        bus.PCPlus4F  = pcf + 32'd4;
        bus.BranchD   = br;
        bus.PCSrcD    = src;
        bus.PCBranchD = tgt;
        bus.PCPlus4D  = p4d;
        bus.StallD    = stl;
        bus.StallF    = stl;
        cur_resolve   = br && !stl;
        cur_mis       = 1'b0;
        #4;
    endtask

    task automatic chk_mis(input string tag, input logic exp);
        chk(tag, {31'd0, bus.MispredictD}, {31'd0, exp});
        chk({tag, "_flush"}, {31'd0, bus.FlushD}, {31'd0, exp});
        cur_mis = exp;
    endtask

    task automatic adv;
        @(posedge clk);
        if (cur_resolve) exp_br++;
        if (cur_mis) exp_mis++;
        cur_resolve = 1'b0;
        cur_mis = 1'b0;
        #1;
    endtask

    task automatic chk_stats(input string tag);
`ifdef BRANCH_PRED_STATS_EN
        chk({tag, "_brcnt"}, branch_cnt, exp_br);
        chk({tag, "_miscnt"}, mispred_cnt, exp_mis);
`else
        $display("stats %s not built", tag);
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.PCF = '0; bus.PCPlus4F = 32'd4; bus.StallF = 1'b0; bus.StallD = 1'b0;
        bus.BranchD = 1'b0; bus.PCSrcD = 1'b0; bus.PCBranchD = '0; bus.PCPlus4D = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        step(PC_BR, 0, 0, 0, 0, 0);
        chk("rst_pred", {31'd0, bus.PredTakenF}, 0);
        chk("rst_next", bus.NextPCF, PC_BR4);
        chk_mis("rst_mis", 0);
        chk_stats("rst");
        adv;

        step(PC_BR4, 1, 1, PC_TGT, PC_BR4, 0);
        chk_mis("cold_mis", 1);
        chk("cold_next", bus.NextPCF, PC_TGT);
        adv;

        step(PC_BR, 0, 0, 0, 0, 0);
        chk("warm_pred", {31'd0, bus.PredTakenF}, 1);
        chk("warm_next", bus.NextPCF, PC_TGT);
        adv;

        step(PC_TGT, 1, 1, PC_TGT, PC_BR4, 0);
        chk_mis("warm_mis", 0);
        chk("warm_tnext", bus.NextPCF, PC_TGT4);
        adv;

        for (int i = 0; i < 3; i++) begin
            step(PC_BR, 0, 0, 0, 0, 0);
            chk("sat_pred", {31'd0, bus.PredTakenF}, 1);
            adv;
            step(PC_TGT, 1, 1, PC_TGT, PC_BR4, 0);
            chk_mis("sat_mis", 0);
            adv;
        end

        step(PC_BR, 0, 0, 0, 0, 0);
        chk("nt_pred", {31'd0, bus.PredTakenF}, 1);
        adv;
        step(PC_TGT, 1, 0, 0, PC_BR4, 0);
        chk_mis("nt_mis", 1);
        chk("nt_next", bus.NextPCF, PC_BR4);
        adv;

        step(PC_BR, 0, 0, 0, 0, 0);
        chk("nt_still", {31'd0, bus.PredTakenF}, 1);
        chk("nt_snext", bus.NextPCF, PC_TGT);
        adv;

        step(PC_TGT, 1, 0, 0, PC_BR4, 1);
        chk_mis("stall1_mis", 0);
        chk("stall1_next", bus.NextPCF, PC_TGT4);
        adv;
        step(PC_BR, 1, 0, 0, PC_BR4, 1);
        chk_mis("stall2_mis", 0);
        chk("stall2_pred", {31'd0, bus.PredTakenF}, 1);
        adv;
        step(PC_TGT, 1, 0, 0, PC_BR4, 0);
        chk_mis("release_mis", 1);
        chk("release_next", bus.NextPCF, PC_BR4);
        adv;
        step(PC_BR, 1, 0, 0, PC_BR4, 0);
        chk_mis("once_mis", 0);
        chk("once_pred", {31'd0, bus.PredTakenF}, 0);
        adv;

        step(PC_BR4, 1, 1, PC_TGT, PC_BR4, 0);
        chk_mis("retrain_mis", 1);
        adv;
        step(PC_ALIAS, 0, 0, 0, 0, 0);
        chk("alias_pred", {31'd0, bus.PredTakenF}, 0);
        chk("alias_next", bus.NextPCF, PC_ALIAS + 32'd4);
        adv;
        step(PC_BR, 0, 0, 0, 0, 0);
        chk("orig_pred", {31'd0, bus.PredTakenF}, 1);
        adv;

        step(PC_TGT, 1, 1, PC_TGT2, PC_BR4, 0);
        chk_mis("tgt_mis", 1);
        chk("tgt_next", bus.NextPCF, PC_TGT2);
        adv;
        step(PC_BR, 0, 0, 0, 0, 0);
        chk("tgt_newnext", bus.NextPCF, PC_TGT2);
        adv;
        step(PC_BR, 1, 0, 0, PC_BR4, 0);
        chk_mis("dec1_mis", 1);
        adv;
        step(PC_BR, 0, 0, 0, 0, 0);
        chk("dec1_pred", {31'd0, bus.PredTakenF}, 1);
        adv;
        step(PC_BR, 1, 0, 0, PC_BR4, 0);
        chk_mis("rbw_mis", 1);
        chk("rbw_pred", {31'd0, bus.PredTakenF}, 1);
        chk("rbw_next", bus.NextPCF, PC_BR4);
        adv;
        step(PC_BR, 0, 0, 0, 0, 0);
        chk("post_pred", {31'd0, bus.PredTakenF}, 0);
        chk("post_next", bus.NextPCF, PC_BR4);
        chk_stats("mid");
        adv;

        step(PC_BR4, 1, 1, PC_TGT, PC_BR4, 0);
        chk_mis("pre_rst_mis", 1);
        adv;
        step(PC_BR, 0, 0, 0, 0, 0);
        chk("pre_rst_pred", {31'd0, bus.PredTakenF}, 1);
        adv;
        step(PC_TGT, 1, 0, 0, PC_BR4, 0);
        rst = 1'b1;
        adv;
        rst = 1'b0;
        exp_br = 0;
        exp_mis = 0;
        step(PC_BR, 1, 0, 0, PC_BR4, 0);
        chk_mis("mrst_mis", 0);
        chk("mrst_pred", {31'd0, bus.PredTakenF}, 0);
        chk("mrst_next", bus.NextPCF, PC_BR4);
        chk_stats("mrst");
        adv;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
Dynamic branch-prediction controller for the 5-stage MIPS pipeline. It owns the fetch next-PC select, so a branch can be redirected in Fetch instead of waiting for Decode.
- Fetch: looks up a direct-mapped BTB/BHT with PCF and produces a predicted next PC.
- Decode: compares the prediction with the Decode-stage branch resolution (PCSrcD, PCBranchD), then trains the tables.
- On a mispredict: redirects fetch and flushes the IF/ID register.

Parameters:
- BHT_IDX_W, 6, index width; table depth is 2**BHT_IDX_W entries (PC[BHT_IDX_W+1:2]).
- CNT_INIT, 2'b01, reset value of every 2-bit counter (weakly not-taken).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- PCF  in  32  fetch-stage PC.
- PCPlus4F  in  32  PCF+4.
- StallF  in  1  hazard-unit stall of the PC/fetch stage.
- StallD  in  1  hazard-unit stall of the IF/ID register.
- BranchD  in  1  decode instruction is a conditional branch.
- PCSrcD  in  1  resolved branch taken (EqualD & BranchD).
- PCBranchD  in  32  resolved branch target.
- PCPlus4D  in  32  decode PC+4.
- PredTakenF  out  1  fetch prediction: taken.
- NextPCF  out  32  value to load into the PC register.
- FlushD  out  1  clear IF/ID (wrong-path instruction in fetch).
- MispredictD  out  1  mispredict detected this cycle.

Behaviour:
- Table storage, per entry:
  - valid (1 bit)
  - tag (PC[31:BHT_IDX_W+2])
  - target (32 bits)
  - cnt (2-bit saturating counter)
- Reset (rst=1 at a rising edge):
  - All valid bits cleared and all cnt set to CNT_INIT.
  - Decode tracking registers cleared.
  - Outputs after reset: PredTakenF=0, NextPCF=PCPlus4F, FlushD=0, MispredictD=0.
- Fetch lookup is combinational and sees the state before this edge's write (read-before-write).
  - hitF = valid[idx] & (tag[idx]==PCF tag bits).
  - PredTakenF = hitF & cnt[idx][1].
  - PredTargetF = target[idx].
- F->D tracking registers: PredTakenD, PredTargetD, PCD.
  - rst or FlushD: cleared, and PredTakenD=0.
  - StallD (and not FlushD): hold.
  - Otherwise: load from F.
- Resolution is valid only when resolveD = BranchD & ~StallD.
  - MispredictD = resolveD & ((PCSrcD != PredTakenD) | (PCSrcD & PredTakenD & PredTargetD != PCBranchD)).
  - FlushD = MispredictD. It is combinational, one cycle, and takes effect at the same edge as the redirect.
- NextPCF priority:
  1. MispredictD: PCSrcD ? PCBranchD : PCPlus4D.
  2. PredTakenF: PredTargetF.
  3. Otherwise: PCPlus4F.
- StallF is not gated inside this block; the PC register honours it.
- MispredictD overrides StallF. The hazard unit never asserts both, because StallF implies StallD, and StallD blocks resolution.
- Training, at the edge where resolveD=1, using index and tag taken from PCD:
  - cnt saturates: taken increments to max 2'b11; not-taken decrements to min 2'b00.
  - Taken: valid=1, tag and target written from PCD/PCBranchD.
  - Not-taken: valid and target unchanged.
- Same index looked up in F and trained in D in the same cycle: F sees the old value.
- Non-branch in D with PredTakenD=1 (tag alias): not treated as a mispredict. This cannot occur with a full tag; no action is required.
- Mid-operation rst: the tables are re-initialised and any pending redirect is dropped.

Optional Feature:
Macro BRANCH_PRED_STATS_EN.
- Defined:
  - Adds outputs BranchCnt[31:0] and MispredCnt[31:0].
  - BranchCnt increments on every resolveD; MispredCnt increments on every MispredictD.
  - Both wrap at 2**32 and clear on rst.
- Undefined: the ports and the counters are absent, and the core behaviour is identical.

Decomposition:
- Shared package/include holds:
  - localparam CNT_SNT=2'b00, CNT_WNT=2'b01, CNT_WT=2'b10, CNT_ST=2'b11.
  - Tag-width constant (30-BHT_IDX_W).
  - Table-entry struct/field widths.
- One natural sub-module: bp_sat_counter, a combinational 2-bit saturating next-state function given current state and taken.
- Table arrays and tracking registers stay in branch_predict_ctrl.

Test Plan:
- Reset then PCF=0x00400010 → PredTakenF=0, NextPCF=0x00400014, FlushD=0.
- Cold taken branch: PCD=0x00400010, BranchD=1, PCSrcD=1, PCBranchD=0x00400040 → MispredictD=1, FlushD=1, NextPCF=0x00400040. The entry becomes valid with cnt=2'b10. The next fetch of 0x00400010 gives PredTakenF=1 and NextPCF=0x00400040.
- Saturation: resolve the same branch taken 4× → cnt=2'b11. Then one not-taken → cnt=2'b10, still predicted taken. The not-taken resolution redirects to PCPlus4D=0x00400014 with FlushD=1.
- StallD=1 while BranchD=1 with a mispredict pending → MispredictD=0, no table write, tracking regs held. On release, the mispredict fires exactly once.
- Aliasing: 0x00400010 and 0x00400110 (BHT_IDX_W=6) share an index. Train the first taken, then fetch the second → tag miss, PredTakenF=0.
- Same-cycle training and lookup on one index → F output reflects the pre-update cnt. With BRANCH_PRED_STATS_EN, after the above sequence BranchCnt and MispredCnt match the scoreboard.
